peripheral_arbiter: RTL and testbench

//  Shares one BIU peripheral memory slave port between MASTERS requesters with round-robin arbitration.
//  A grant is held for a whole classic cycle or burst, with a one-cycle idle gap between owners so the slave

---
 rtl/peripheral_arbiter_if.sv | 50 +++++
 rtl/peripheral_arbiter.sv | 147 ++++++++++++++
 tb/tb_peripheral_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_arbiter_if.sv
// Bus bundle between the BIU requesters, the arbiter and the peripheral memory slave port.
// The "master" modport is the requester/memory side; the arbiter is attached through the "slave" modport.
interface peripheral_arbiter_if #(
   parameter int MASTERS = 2
);
   // Handshake: a requester is valid while m_stb_i & m_lock_i are both high; a beat completes in a
   // cycle where the owner is valid and s_ack_i (or s_err_i) is high. No back-pressure beyond that.
   logic [MASTERS-1:0]    m_stb_i;
   logic [MASTERS-1:0]    m_lock_i;
   logic [MASTERS-1:0]    m_we_i;
   logic [32*MASTERS-1:0] m_adr_i;
   logic [4*MASTERS-1:0]  m_size_i;
   logic [2*MASTERS-1:0]  m_type_i;
   logic [3*MASTERS-1:0]  m_prot_i;
   logic [32*MASTERS-1:0] m_d_i;
   logic [32*MASTERS-1:0] m_q_o;
   logic [MASTERS-1:0]    m_ack_o;
   logic [MASTERS-1:0]    m_err_o;

   logic                  s_stb_o;
   logic                  s_lock_o;
   logic                  s_we_o;
   logic [31:0]           s_adr_o;
   logic [3:0]            s_size_o;
   logic [1:0]            s_type_o;
   logic [2:0]            s_prot_o;
   logic [31:0]           s_d_o;
   logic [31:0]           s_q_i;
   logic                  s_ack_i;
   logic                  s_err_i;

   // Arbiter FSM state, exported for observation (0 idle, 1 grant, 2 gap)
   logic [1:0]            arb_state;

   modport master (
      output m_stb_i, m_lock_i, m_we_i, m_adr_i, m_size_i, m_type_i, m_prot_i, m_d_i,
      input  m_q_o, m_ack_o, m_err_o,
      input  s_stb_o, s_lock_o, s_we_o, s_adr_o, s_size_o, s_type_o, s_prot_o, s_d_o,
      output s_q_i, s_ack_i, s_err_i,
      input  arb_state
   );

   modport slave (
      input  m_stb_i, m_lock_i, m_we_i, m_adr_i, m_size_i, m_type_i, m_prot_i, m_d_i,
      output m_q_o, m_ack_o, m_err_o,
      output s_stb_o, s_lock_o, s_we_o, s_adr_o, s_size_o, s_type_o, s_prot_o, s_d_o,
      input  s_q_i, s_ack_i, s_err_i,
      output arb_state
   );
endinterface

// File: rtl/peripheral_arbiter.sv
// Round-robin arbiter sharing one peripheral memory slave port between MASTERS BIU requesters.
// Grants are held per classic cycle or burst, separated by one idle GAP cycle, with a stall watchdog.
module peripheral_arbiter #(
   parameter int MASTERS = 2,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   peripheral_arbiter_if.slave bus,
   output logic [MASTERS-1:0] grant_o,
   output logic               busy_o
);
   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam logic [IW:0] M_W = (IW+1)'(MASTERS);
   localparam logic [7:0] WD_MAX = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e             state_q;
   logic [MASTERS-1:0] grant_q;
   logic [IW-1:0]      owner_q;
   logic [IW-1:0]      ptr_q;
   logic [7:0]         wd_q;

   logic [MASTERS-1:0] req;
   logic               pick_valid;
   logic [IW-1:0]      pick_idx;
   logic [IW:0]        rr_sum;
   logic               in_grant;
   logic               own_req, own_stb, own_lock, own_we;
   logic [31:0]        own_adr, own_d;
   logic [3:0]         own_size;
   logic [1:0]         own_type;
   logic [2:0]         own_prot;
   logic               wd_hit;
   logic               final_ack;
   logic               release_c;

   assign req      = bus.m_stb_i & bus.m_lock_i;
   assign in_grant = (state_q == ST_GRANT);

   // Scan from ptr downward-overwriting so the first requester at or after ptr wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      rr_sum     = '0;
      for (int k = MASTERS-1; k >= 0; k--) begin
         rr_sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (rr_sum >= M_W) rr_sum = rr_sum - M_W;
         if (req[rr_sum[IW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = rr_sum[IW-1:0];
         end
      end
   end

   always_comb begin
      own_req  = 1'b0;
      own_stb  = 1'b0;
      own_lock = 1'b0;
      own_we   = 1'b0;
      own_adr  = '0;
      own_d    = '0;
      own_size = '0;
      own_type = '0;
      own_prot = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (owner_q == IW'(i)) begin
            own_req  = req[i];
            own_stb  = bus.m_stb_i[i];
            own_lock = bus.m_lock_i[i];
            own_we   = bus.m_we_i[i];
            own_adr  = bus.m_adr_i[32*i +: 32];
            own_d    = bus.m_d_i[32*i +: 32];
            own_size = bus.m_size_i[4*i +: 4];
            own_type = bus.m_type_i[2*i +: 2];
            own_prot = bus.m_prot_i[3*i +: 3];
         end
      end
   end

   // An ack in the watchdog's final cycle takes precedence and suppresses the timeout error.
   assign wd_hit    = in_grant && (wd_q == WD_MAX) && !bus.s_ack_i;
   assign final_ack = bus.s_ack_i && ((own_prot == 3'b000) || (own_prot == 3'b111));
   assign release_c = in_grant && (final_ack || !own_req || bus.s_err_i || wd_hit);

   always_comb begin
      bus.s_stb_o  = in_grant & own_stb;
      bus.s_lock_o = in_grant & own_lock;
      bus.s_we_o   = in_grant & own_we;
      bus.s_adr_o  = in_grant ? own_adr  : '0;
      bus.s_size_o = in_grant ? own_size : '0;
      bus.s_type_o = in_grant ? own_type : '0;
      bus.s_prot_o = in_grant ? own_prot : '0;
      bus.s_d_o    = in_grant ? own_d    : '0;
      bus.m_ack_o  = grant_q & {MASTERS{bus.s_ack_i}};
      bus.m_err_o  = grant_q & {MASTERS{bus.s_err_i | wd_hit}};
      bus.m_q_o    = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (grant_q[i]) bus.m_q_o[32*i +: 32] = bus.s_q_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
      end else begin
         case (state_q)
            ST_GRANT: begin
               if (release_c) begin
                  state_q <= ST_GAP;
                  grant_q <= '0;
                  ptr_q   <= (owner_q == IW'(MASTERS-1)) ? '0 : owner_q + IW'(1);
                  wd_q    <= '0;
               end else if (bus.s_ack_i) begin
                  wd_q    <= '0;
               end else if (wd_q != 8'hFF) begin
                  wd_q    <= wd_q + 8'd1;
               end
            end
            default: begin
               if (pick_valid) begin
                  state_q <= ST_GRANT;
                  grant_q <= MASTERS'(1) << pick_idx;
                  owner_q <= pick_idx;
               end else begin
                  state_q <= ST_IDLE;
                  grant_q <= '0;
               end
               wd_q <= '0;
            end
         endcase
      end
   end

   assign grant_o       = grant_q;
   assign busy_o        = in_grant;
   assign bus.arb_state = state_q;
endmodule

// File: tb/tb_peripheral_arbiter.sv
// Randomised and directed bench for peripheral_arbiter, checked every cycle against a transaction-level
// model (current owner index, round-robin pointer, stall count) plus hand-computed expectations.
module tb_peripheral_arbiter;
   localparam int M  = 3;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [M-1:0] grant;
   logic         busy;

   peripheral_arbiter_if #(.MASTERS(M)) bus();

   peripheral_arbiter #(.MASTERS(M), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .bus(bus), .grant_o(grant), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: own = -1 when nobody holds the port (idle or gap), else owner index
   int own, ptr, wd;
   logic [M-1:0] last_ack;
   logic [M-1:0] exp_q[$];

   bit          active[M];
   int          beats[M];
   logic [2:0]  fin[M];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      own = -1;
      ptr = 0;
      wd  = 0;
   endtask

   task automatic clear_inputs();
      bus.m_stb_i = '0; bus.m_lock_i = '0; bus.m_we_i = '0; bus.m_adr_i = '0;
      bus.m_size_i = '0; bus.m_type_i = '0; bus.m_prot_i = '0; bus.m_d_i = '0;
      bus.s_q_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Compare all outputs to the model at the current negedge, advance the model, move past posedge.
   task automatic tick();
      logic [M-1:0]   req, e_grant, e_ack, e_err;
      logic [32*M-1:0] e_q;
      logic [75:0]    e_s, a_s;
      logic [2:0]     p;
      bit             wdh, rel, found;
      int             j;
      e_grant = '0; e_ack = '0; e_err = '0; e_q = '0; e_s = '0; wdh = 0;
      if (own >= 0 && !rst) begin
         e_grant = M'(1) << own;
         wdh = (wd == TO) && !bus.s_ack_i;
         e_ack[own] = bus.s_ack_i;
         e_err[own] = bus.s_err_i | wdh;
         e_q[32*own +: 32] = bus.s_q_i;
         e_s = {bus.m_stb_i[own], bus.m_lock_i[own], bus.m_we_i[own], bus.m_adr_i[32*own +: 32],
                bus.m_size_i[4*own +: 4], bus.m_type_i[2*own +: 2], bus.m_prot_i[3*own +: 3],
                bus.m_d_i[32*own +: 32]};
      end
      a_s = {bus.s_stb_o, bus.s_lock_o, bus.s_we_o, bus.s_adr_o, bus.s_size_o, bus.s_type_o,
             bus.s_prot_o, bus.s_d_o};
      check("grant", grant, e_grant);
      check("busy", busy, (own >= 0 && !rst));
      check("s_bus", a_s, e_s);
      check("m_ack", bus.m_ack_o, e_ack);
      check("m_err", bus.m_err_o, e_err);
      check("m_q", bus.m_q_o, e_q);
      last_ack = e_ack;
      if (!rst) begin
         req = bus.m_stb_i & bus.m_lock_i;
         if (own >= 0) begin
            p = bus.m_prot_i[3*own +: 3];
            rel = (bus.s_ack_i && (p == 3'b000 || p == 3'b111)) || !req[own] || bus.s_err_i || wdh;
            if (rel) begin
               ptr = (own + 1) % M;
               own = -1;
               wd  = 0;
            end else if (bus.s_ack_i) wd = 0;
            else if (wd < 255) wd++;
         end else begin
            found = 0;
            for (int k = 0; k < M; k++) begin
               j = (ptr + k) % M;
               if (!found && req[j]) begin
                  found = 1;
                  own = j;
                  wd = 0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      model_reset();
      settle(); tick();
      rst = 1'b0;
   endtask

   task automatic set_master(input int i, input logic r, input logic [31:0] adr,
                             input logic [2:0] prot, input logic [1:0] typ);
      bus.m_stb_i[i] = r; bus.m_lock_i[i] = r;
      bus.m_adr_i[32*i +: 32] = adr;
      bus.m_prot_i[3*i +: 3] = prot;
      bus.m_type_i[2*i +: 2] = typ;
   endtask

   initial begin
      logic [31:0] wrap_adr[4];
      wrap_adr[0] = 32'h0C; wrap_adr[1] = 32'h00; wrap_adr[2] = 32'h04; wrap_adr[3] = 32'h08;
      clear_inputs();
      model_reset();
      last_ack = '0;
      #1;
      settle();
      check("reset_grant", grant, 3'b000);
      check("reset_busy", busy, 1'b0);
      check("reset_s_stb", bus.s_stb_o, 1'b0);
      tick();
      rst = 1'b0;

      // Single classic read from m0
      set_master(0, 1'b1, 32'h10, 3'b000, 2'd0);
      settle(); check("t1_idle_grant", grant, 3'b000); tick();
      settle();
      check("t1_grant", grant, 3'b001);
      check("t1_s_adr", bus.s_adr_o, 32'h10);
      check("t1_s_stb", bus.s_stb_o, 1'b1);
      tick();
      bus.s_ack_i = 1'b1; bus.s_q_i = 32'hCAFE0004;
      settle();
      check("t1_ack", bus.m_ack_o, 3'b001);
      check("t1_q", bus.m_q_o[31:0], 32'hCAFE0004);
      check("t1_q_other", bus.m_q_o[63:32], 32'h0);
      tick();
      clear_inputs();
      settle(); check("t1_gap_grant", grant, 3'b000); check("t1_gap_stb", bus.s_stb_o, 1'b0); tick();
      settle(); check("t1_idle_busy", busy, 1'b0); tick();

      // Contention after reset: m0, gap, m1, gap, m0 again
      reset_dut();
      set_master(0, 1'b1, 32'h20, 3'b000, 2'd0);
      set_master(1, 1'b1, 32'h30, 3'b000, 2'd0);
      bus.s_ack_i = 1'b1;
      exp_q = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
      while (exp_q.size() > 0) begin
         settle(); check("t2_grant_seq", grant, exp_q.pop_front()); tick();
      end
      clear_inputs();
      settle(); tick();
      settle(); tick();

      // Wrap4 incrementing burst on m1: three 010 beats then a 111 beat
      set_master(1, 1'b1, wrap_adr[0], 3'b010, 2'd1);
      settle(); tick();
      for (int b = 0; b < 4; b++) begin
         set_master(1, 1'b1, wrap_adr[b], (b < 3) ? 3'b010 : 3'b111, 2'd1);
         bus.s_ack_i = 1'b1;
         settle();
         check("t3_grant", grant, 3'b010);
         check("t3_lock", bus.s_lock_o, 1'b1);
         check("t3_adr", bus.s_adr_o, wrap_adr[b]);
         check("t3_ack", bus.m_ack_o, 3'b010);
         tick();
      end
      clear_inputs();
      settle(); check("t3_released", grant, 3'b000); tick();

      // Watchdog on m2 with m0 waiting
      set_master(2, 1'b1, 32'h44, 3'b000, 2'd0);
      set_master(0, 1'b1, 32'h48, 3'b000, 2'd0);
      settle(); tick();
      for (int k = 0; k <= TO; k++) begin
         settle();
         check("t4_err", bus.m_err_o, (k == TO) ? 3'b100 : 3'b000);
         tick();
      end
      set_master(2, 1'b0, 32'h0, 3'b000, 2'd0);
      settle(); check("t4_gap", grant, 3'b000); tick();

      // Slave error on m0 at an out-of-range address
      set_master(0, 1'b1, 32'h400, 3'b000, 2'd0);
      bus.s_err_i = 1'b1;
      settle();
      check("t5_grant", grant, 3'b001);
      check("t5_err", bus.m_err_o, 3'b001);
      tick();
      clear_inputs();
      settle(); check("t5_released", grant, 3'b000); tick();

      // Async reset during beat 2 of an m1 burst, then m0 wins a tie
      set_master(1, 1'b1, 32'h80, 3'b010, 2'd0);
      settle(); tick();
      bus.s_ack_i = 1'b1;
      settle(); check("t6_beat1", grant, 3'b010); tick();
      bus.s_ack_i = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_async_stb", bus.s_stb_o, 1'b0);
      check("t6_async_grant", grant, 3'b000);
      check("t6_async_lock", bus.s_lock_o, 1'b0);
      model_reset();
      set_master(0, 1'b1, 32'h90, 3'b000, 2'd0);
      settle(); tick();
      rst = 1'b0;
      settle(); tick();
      settle(); check("t6_tie_m0", grant, 3'b001); tick();
      clear_inputs();
      settle(); tick();
      settle(); tick();

      // Randomised traffic at three slave ack rates
      for (int i = 0; i < M; i++) begin active[i] = 0; beats[i] = 0; fin[i] = 3'b000; end
      for (int ph = 0; ph < 3; ph++) begin
         int pct;
         pct = (ph == 0) ? 70 : (ph == 1) ? 15 : 0;
         for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < M; i++) begin
               if (!active[i] && $urandom_range(0, 3) == 0) begin
                  active[i] = 1;
                  beats[i]  = $urandom_range(1, 4);
                  fin[i]    = $urandom_range(0, 1) ? 3'b111 : 3'b000;
               end
               bus.m_stb_i[i]  = active[i] | ($urandom_range(0, 9) == 0);
               bus.m_lock_i[i] = active[i];
               bus.m_we_i[i]   = 1'($urandom_range(0, 1));
               bus.m_adr_i[32*i +: 32] = $urandom;
               bus.m_d_i[32*i +: 32]   = $urandom;
               bus.m_size_i[4*i +: 4]  = 4'($urandom_range(0, 15));
               bus.m_type_i[2*i +: 2]  = 2'($urandom_range(0, 3));
               bus.m_prot_i[3*i +: 3]  = (beats[i] > 1) ? 3'b010 : fin[i];
            end
            bus.s_ack_i = ($urandom_range(0, 99) < pct);
            bus.s_err_i = ($urandom_range(0, 59) == 0);
            bus.s_q_i   = $urandom;
            settle(); tick();
            for (int i = 0; i < M; i++) begin
               if (last_ack[i] && active[i]) begin
                  beats[i]--;
                  if (beats[i] == 0) active[i] = 0;
               end
               if (active[i] && $urandom_range(0, 39) == 0) active[i] = 0;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
